// File: rtl/edge_event_arbiter.sv
// Edge-event scheduler: latches per-channel edges as pending events and offers them round-robin; EDGE_EVENT_ARB_OVF_EN adds sticky ovf[]/ovf_clr.
// Latency: edge sampled at clk k -> pending after k -> evt_valid after k+1; at most one event per two cycles.
// Backpressure: evt_id/evt_valid hold while evt_ready is low; further edges on a pending channel merge into one event.
module edge_event_arbiter #(
    parameter int N         = 4,
    parameter int IDW       = 2,
    parameter int EDGE_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ready,
    output logic [N-1:0]   pending
`ifdef EDGE_EVENT_ARB_OVF_EN
    ,
    output logic [N-1:0]   ovf,
    input  logic           ovf_clr
`endif
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   prev_q, prev_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           evt_valid_q, evt_valid_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]   edge_det;
    logic [N-1:0]   clr_mask;
    logic [N-1:0]   merge_ovf;
    logic           accept;
    logic           found;
    logic [IDW-1:0] winner;

    always_comb begin
        case (EDGE_MODE)
            0:       edge_det = in & ~prev_q;
            1:       edge_det = ~in & prev_q;
            default: edge_det = in ^ prev_q;
        endcase
    end

    assign accept    = (state_q == OFFER) && evt_ready;
    assign clr_mask  = accept ? ({{(N-1){1'b0}}, 1'b1} << evt_id_q) : '0;
    // A fresh edge on the channel being accepted is a new event, not a merge.
    assign merge_ovf = edge_det & pending_q & ~clr_mask;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && pending_q[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)  state_d = OFFER;
            OFFER:   if (accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prev_d      = in;
        pending_d   = (pending_q & ~clr_mask) | edge_det;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                evt_valid_d = found;
                if (found) evt_id_d = winner;
            end
            OFFER: begin
                if (accept) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = (evt_id_q == IDW'(N - 1)) ? '0 : evt_id_q + 1'b1;
                end
            end
            default: evt_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        if (rst) begin
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;

`ifdef EDGE_EVENT_ARB_OVF_EN
    logic [N-1:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = (ovf_clr ? '0 : ovf_q) | merge_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= '0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^merge_ovf;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed vector table for a rising-edge instance plus hand sequences on a both-edge instance.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] in_a, in_b;
    logic       rdy_a, rdy_b;
    logic       vld_a, vld_b;
    logic [1:0] id_a, id_b;
    logic [3:0] pend_a, pend_b;
`ifdef EDGE_EVENT_ARB_OVF_EN
    logic [3:0] ovf_a, ovf_b;
    logic       ovf_clr_a, ovf_clr_b;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N(4), .IDW(2), .EDGE_MODE(0)) dut_a (
        .clk(clk), .rst(rst_a), .in(in_a),
        .evt_valid(vld_a), .evt_id(id_a), .evt_ready(rdy_a), .pending(pend_a)
`ifdef EDGE_EVENT_ARB_OVF_EN
        , .ovf(ovf_a), .ovf_clr(ovf_clr_a)
`endif
    );

    edge_event_arbiter #(.N(4), .IDW(2), .EDGE_MODE(2)) dut_b (
        .clk(clk), .rst(rst_b), .in(in_b),
        .evt_valid(vld_b), .evt_id(id_b), .evt_ready(rdy_b), .pending(pend_b)
`ifdef EDGE_EVENT_ARB_OVF_EN
        , .ovf(ovf_b), .ovf_clr(ovf_clr_b)
`endif
    );

    typedef struct {
        logic [3:0] in;
        logic       rdy;
        logic       vld;
        logic [1:0] id;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {in, ready} applied before an edge -> {valid, id, pending} seen after it
        tbl[0]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[2]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[3]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100};
        tbl[4]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[5]  = '{4'b0100, 1'b1, 1'b0, 2'd2, 4'b0000};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
        tbl[7]  = '{4'b1011, 1'b1, 1'b0, 2'd2, 4'b1011};
        tbl[8]  = '{4'b1011, 1'b1, 1'b1, 2'd3, 4'b1011};
        tbl[9]  = '{4'b1011, 1'b1, 1'b0, 2'd3, 4'b0011};
        tbl[10] = '{4'b1011, 1'b1, 1'b1, 2'd0, 4'b0011};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0010};
        tbl[12] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000};
        tbl[14] = '{4'b1001, 1'b0, 1'b0, 2'd1, 4'b1001};
        tbl[15] = '{4'b1001, 1'b0, 1'b1, 2'd3, 4'b1001};
        tbl[16] = '{4'b0001, 1'b0, 1'b1, 2'd3, 4'b1001};
        tbl[17] = '{4'b0011, 1'b0, 1'b1, 2'd3, 4'b1011};
        tbl[18] = '{4'b0011, 1'b0, 1'b1, 2'd3, 4'b1011};
        tbl[19] = '{4'b0011, 1'b1, 1'b0, 2'd3, 4'b0011};
        tbl[20] = '{4'b0011, 1'b0, 1'b1, 2'd0, 4'b0011};
        tbl[21] = '{4'b0011, 1'b1, 1'b0, 2'd0, 4'b0010};
        tbl[22] = '{4'b0001, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[23] = '{4'b0011, 1'b1, 1'b0, 2'd1, 4'b0010};
        tbl[24] = '{4'b0011, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[25] = '{4'b0011, 1'b1, 1'b0, 2'd1, 4'b0000};

        rst_a = 1'b1; in_a = 4'b1111; rdy_a = 1'b0;
        rst_b = 1'b1; in_b = 4'b0000; rdy_b = 1'b0;
`ifdef EDGE_EVENT_ARB_OVF_EN
        ovf_clr_a = 1'b0; ovf_clr_b = 1'b0;
`endif
        tick(); tick();
        chk("a_reset_valid", 32'(vld_a), 32'd0);
        chk("a_reset_pending", 32'(pend_a), 32'd0);
        chk("a_reset_id", 32'(id_a), 32'd0);
        rst_a = 1'b0;

        for (int i = 0; i < 26; i++) begin
            in_a  = tbl[i].in;
            rdy_a = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(vld_a), 32'(tbl[i].vld));
            chk($sformatf("v%0d_id", i), 32'(id_a), 32'(tbl[i].id));
            chk($sformatf("v%0d_pending", i), 32'(pend_a), 32'(tbl[i].pend));
`ifdef EDGE_EVENT_ARB_OVF_EN
            chk($sformatf("v%0d_ovf", i), 32'(ovf_a), 32'd0);
`endif
        end

        // Both-edge instance: three toggles of ch1 under backpressure merge into one event.
        rst_b = 1'b0;
        tick();
        chk("b_idle_pending", 32'(pend_b), 32'd0);
        in_b = 4'b0010; tick();
        chk("b_t1_pending", 32'(pend_b), 32'b0010);
        chk("b_t1_valid", 32'(vld_b), 32'd0);
        in_b = 4'b0000; tick();
        chk("b_t2_valid", 32'(vld_b), 32'd1);
        chk("b_t2_id", 32'(id_b), 32'd1);
        in_b = 4'b0010; tick();
        chk("b_t3_pending", 32'(pend_b), 32'b0010);
        chk("b_t3_valid", 32'(vld_b), 32'd1);
        chk("b_t3_id", 32'(id_b), 32'd1);
`ifdef EDGE_EVENT_ARB_OVF_EN
        chk("b_ovf_set", 32'(ovf_b), 32'b0010);
        ovf_clr_b = 1'b1; tick();
        ovf_clr_b = 1'b0;
        chk("b_ovf_clr", 32'(ovf_b), 32'd0);
`else
        tick();
`endif
        chk("b_hold_id", 32'(id_b), 32'd1);
        rst_b = 1'b1; in_b = 4'b1010; tick();
        chk("b_rst_valid", 32'(vld_b), 32'd0);
        chk("b_rst_pending", 32'(pend_b), 32'd0);
        rst_b = 1'b0; tick();
        chk("b_post_rst_pending", 32'(pend_b), 32'd0);
        chk("b_post_rst_valid", 32'(vld_b), 32'd0);
        in_b = 4'b1000; tick();
        chk("b_fall_pending", 32'(pend_b), 32'b0010);
        rdy_b = 1'b1; tick();
        chk("b_fall_offer", 32'(id_b), 32'd1);
        tick();
        chk("b_fall_accept", 32'(pend_b), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
